// File: rtl/ifetch_ctrl.sv
// Instruction-fetch sequencer: PC register, ROM address drive, and a small fetch FIFO to decode.
// Define IFETCH_PERF_EN to add the fetch/stall performance counters.
module ifetch_ctrl #(
   parameter int unsigned          ADDR_WIDTH = 64,
   parameter int unsigned          DATA_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC  = 64'h0,
   parameter int unsigned          FIFO_DEPTH = 2
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  fetch_en_i,
   output logic [ADDR_WIDTH-1:0] rom_addr_o,
   input  logic [DATA_WIDTH-1:0] rom_data_i,
   input  logic                  rom_illegal_i,
   input  logic                  redirect_valid_i,
   input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
   output logic                  inst_valid_o,
   input  logic                  inst_ready_i,
   output logic [DATA_WIDTH-1:0] inst_o,
   output logic [ADDR_WIDTH-1:0] inst_pc_o,
   output logic                  inst_fault_o,
   output logic                  halted_o
`ifdef IFETCH_PERF_EN
   ,
   output logic [63:0]           perf_fetch_cnt_o,
   output logic [63:0]           perf_stall_cnt_o
`endif
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   typedef enum logic {ST_RUN, ST_HALT} state_e;

   state_e state_q, state_d;

   logic [ADDR_WIDTH-1:0] pc_q;
   logic [ADDR_WIDTH-1:0] pc_mem    [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0] data_mem  [FIFO_DEPTH];
   logic                  fault_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]      count_q;

   logic fifo_empty, fifo_full, fetch_req, push, pop;

   assign fifo_empty = (count_q == '0);
   assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
   assign pop        = !fifo_empty && inst_ready_i;
   assign fetch_req  = (state_q == ST_RUN) && fetch_en_i && !redirect_valid_i;
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign push       = fetch_req && (!fifo_full || pop);
   assign rom_addr_o = pc_q;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) state_q <= ST_RUN;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (redirect_valid_i)          state_d = ST_RUN;
      else if (push && rom_illegal_i) state_d = ST_HALT;
   end

   always_comb begin
      halted_o     = (state_q == ST_HALT);
      inst_valid_o = !fifo_empty;
      inst_o       = '0;
      inst_pc_o    = '0;
      inst_fault_o = 1'b0;
      if (!fifo_empty) begin
         inst_o       = data_mem[rd_ptr_q];
         inst_pc_o    = pc_mem[rd_ptr_q];
         inst_fault_o = fault_mem[rd_ptr_q];
      end
   end

   // A faulting fetch leaves pc_q on the offending address until a redirect.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         pc_q     <= RESET_PC;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (redirect_valid_i) begin
         pc_q     <= redirect_pc_i;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
            if (!rom_illegal_i) pc_q <= pc_q + ADDR_WIDTH'(4);
         end
         if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({push, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) begin
         pc_mem[wr_ptr_q]    <= pc_q;
         data_mem[wr_ptr_q]  <= rom_illegal_i ? '0 : rom_data_i;
         fault_mem[wr_ptr_q] <= rom_illegal_i;
      end
   end

`ifdef IFETCH_PERF_EN
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         perf_fetch_cnt_o <= '0;
         perf_stall_cnt_o <= '0;
      end else begin
         if (push)                          perf_fetch_cnt_o <= perf_fetch_cnt_o + 64'd1;
         if (fetch_req && fifo_full && !pop) perf_stall_cnt_o <= perf_stall_cnt_o + 64'd1;
      end
   end
`endif

endmodule

// File: doc/ifetch_ctrl.md
Name: ifetch_ctrl

Overview:
Instruction-fetch sequencer for the code ROM. Holds the program counter, drives the ROM's combinational address port, and captures each returned word with its PC and fault flag into a small FIFO. The FIFO feeds the decode stage through a valid/ready handshake. Handles control-flow redirects (branch/trap) with a full flush, and stops fetching after an unaligned/illegal ROM access until redirected.

Parameters:
ADDR_WIDTH, 64, PC / ROM address width
DATA_WIDTH, 32, instruction word width
RESET_PC, 64'h0, PC value loaded on reset
FIFO_DEPTH, 2, fetch buffer entries (power of two, >=2)

Ports:
clk_i  input  1  clock, all state updates on rising edge
rst_ni  input  1  synchronous active-low reset
fetch_en_i  input  1  permit new ROM fetches
rom_addr_o  output  ADDR_WIDTH  ROM address, equals pc_q
rom_data_i  input  DATA_WIDTH  ROM data, combinational from rom_addr_o
rom_illegal_i  input  1  ROM illegal/unaligned flag, combinational
redirect_valid_i  input  1  flush and restart fetch
redirect_pc_i  input  ADDR_WIDTH  new fetch PC
inst_valid_o  output  1  FIFO head valid
inst_ready_i  input  1  decode accepts head
inst_o  output  DATA_WIDTH  head instruction
inst_pc_o  output  ADDR_WIDTH  head PC
inst_fault_o  output  1  head fetched with illegal access (inst_o = 0)
halted_o  output  1  controller in HALT state

Behaviour:
- Reset (rst_ni=0 at edge): pc_q=RESET_PC, FIFO empty, state RUN. Outputs after reset: inst_valid_o=0, inst_o=0, inst_pc_o=0, inst_fault_o=0, halted_o=0, rom_addr_o=RESET_PC. Reset overrides all inputs. Reset mid-stream discards all buffered entries.
- States: RUN, HALT.
- Push condition in RUN: fetch_en_i=1, no redirect, and (count<FIFO_DEPTH or (count==FIFO_DEPTH and pop)). The push writes {pc_q, rom_data_i, rom_illegal_i} and sets pc_q <= pc_q+4, wrapping modulo 2^ADDR_WIDTH.
- Pop: inst_valid_o && inst_ready_i. A push and a pop may happen in the same cycle, at any count.
- Latency: a word fetched at edge N is visible on inst_* after edge N; with an empty FIFO, inst_valid_o rises 1 cycle after the fetch cycle. Sustained throughput is 1 instruction/cycle while ready=1.
- Fault: a push with rom_illegal_i=1 stores inst_o=0 and fault=1, and moves to HALT. pc_q holds the faulting PC. In HALT there are no pushes. Pops continue, so the fault entry drains normally. halted_o=1 in HALT.
- Redirect (highest priority after reset): FIFO is flushed, pc_q <= redirect_pc_i, state <= RUN, no push that cycle. A pop in the same cycle counts as a completed handshake on the old head, which is then discarded by the flush. redirect_pc_i is not checked; a misaligned target produces a fault entry on the next fetch.
- fetch_en_i=0: no pushes, and pc_q holds. Pops continue.
- FIFO full without pop: pc_q holds, and rom_addr_o is stable.
- When FIFO empty: inst_o/inst_pc_o/inst_fault_o driven 0.

Optional Feature:
IFETCH_PERF_EN — when defined, add outputs perf_fetch_cnt_o (64) and perf_stall_cnt_o (64). Both reset to 0 and wrap on overflow.
- perf_fetch_cnt_o increments once per push.
- perf_stall_cnt_o increments each cycle in RUN with fetch_en_i=1, no redirect, and the push blocked by a full FIFO.
When undefined, these ports and counters do not exist, and behaviour is otherwise identical.

Test Plan:
- Reset with RESET_PC=0, ROM words 0..3 = 0x13,0x93,0x113,0x193, ready=1, fetch_en=1 -> inst_valid_o high from cycle 2 after reset release; inst_pc_o 0,4,8,12 on consecutive cycles with matching inst_o.
- ready=0 for 5 cycles from start -> exactly 2 pushes (PC 0,4). rom_addr_o holds 8. On ready=1, PCs 0,4,8 delivered in order with no loss. With IFETCH_PERF_EN, perf_stall_cnt_o=3 at release.
- Redirect to 0x40 while FIFO holds PCs 0x8,0xC -> next valid head is PC 0x40. PCs 0x8/0xC never appear after the redirect cycle.
- Redirect to 0x42 (unaligned) -> one entry PC=0x42, inst_o=0, inst_fault_o=1. halted_o=1, with no further entries. A later redirect to 0x0 clears halted_o, and fetch resumes at 0x0.
- Assert rst_ni=0 mid-stream while the FIFO is full -> next cycle inst_valid_o=0, rom_addr_o=RESET_PC, halted_o=0, and perf counters are 0.
- Push and pop in the same cycle while full, ready=1 continuous for 100 cycles -> 100 sequential PCs, no bubbles after the first.
